// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_if_pkg
// Purpose : Shared types, constants and helpers for the CPU data-memory
//           responder (state encoding, bus widths, byte-to-word addressing).
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } rsp_state_t;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_W     = 32;

  // Word index of a byte address: drops the byte-offset bits.
  function automatic logic [ADDR_W-3:0] word_index(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_responder_if
// Purpose : Request/response valid-ready bundle between the CPU load/store
//           path (master) and the memory responder (slave).
// Ports   : req_valid_i/req_ready_o/req_we_i/req_addr_i/req_wdata_i  request
//           rsp_valid_o/rsp_ready_i/rsp_rdata_o/rsp_err_o             response
//           Suffixes are named from the responder's point of view.
// Revision: 1.0 - initial release
// ============================================================================
interface mem_responder_if;
  import mem_if_pkg::*;

  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [31:0]       req_wdata_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [31:0]       rsp_rdata_o;
  logic              rsp_err_o;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

endinterface
`default_nettype wire

// File: rtl/mem_responder_mem_array.sv
`default_nettype none
// ============================================================================
// Module  : mem_array
// Purpose : Word-wide RAM, synchronous write, combinational read. Contents
//           have no reset so they survive a responder reset.
// Ports   : clk_i            clock
//           i_we             write enable
//           i_waddr/i_wdata  write word index / data
//           i_raddr          read word index
//           o_rdata          read data (combinational)
// Revision: 1.0 - initial release
// ============================================================================
module mem_array #(
  parameter int DEPTH_WORDS = 128,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  wire logic          clk_i,
  input  wire logic          i_we,
  input  wire logic [AW-1:0] i_waddr,
  input  wire logic [31:0]   i_wdata,
  input  wire logic [AW-1:0] i_raddr,
  output logic      [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : mem_responder
// Purpose : Responder end of the CPU data-memory interface. Accepts one
//           load/store at a time, waits LATENCY cycles, then presents the
//           response until the initiator takes it.
// Ports   : clk_i  clock
//           rst_i  asynchronous active-high reset
//           bus    mem_responder_if.slave request/response channels
// Revision: 1.0 - initial release
// ============================================================================
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 2
) (
  input wire logic       clk_i,
  input wire logic       rst_i,
  mem_responder_if.slave bus
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] C_LAT_M1 = 4'(LATENCY - 1);

  rsp_state_t      r_state;
  rsp_state_t      w_state_nxt;
  logic [3:0]      r_cnt;
  logic            r_we;
  logic            r_err;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_rdata;
  logic            r_rsp_err;

  logic            w_accept;
  logic            w_req_err;
  logic            w_mem_we;
  logic [31:0]     w_mem_rdata;

  // Misaligned or beyond the array: flagged at accept, never written.
  assign w_req_err = (bus.req_addr_i[1:0] != 2'b00) ||
                     ({2'b00, word_index(bus.req_addr_i)} >= 32'(DEPTH_WORDS));

  assign w_accept  = (r_state == IDLE) && bus.req_valid_i;

  // Store lands in the array on the accept edge itself; gated by reset so
  // nothing is accepted while reset is held.
  assign w_mem_we  = w_accept && bus.req_we_i && !w_req_err && !rst_i;

  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_mem_array (
    .clk_i   (clk_i),
    .i_we    (w_mem_we),
    .i_waddr (bus.req_addr_i[AW+1:2]),
    .i_wdata (bus.req_wdata_i),
    .i_raddr (r_idx),
    .o_rdata (w_mem_rdata)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_nxt     = r_state;
    bus.req_ready_o = 1'b0;
    bus.rsp_valid_o = 1'b0;
    case (r_state)
      IDLE: begin
        bus.req_ready_o = 1'b1;
        if (bus.req_valid_i) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid_o = 1'b1;
        if (bus.rsp_ready_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Request latch, latency counter and response data
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt     <= 4'd0;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_idx     <= '0;
      r_rdata   <= 32'd0;
      r_rsp_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we  <= bus.req_we_i;
            r_err <= w_req_err;
            r_idx <= bus.req_addr_i[AW+1:2];
            r_cnt <= C_LAT_M1;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            // Read happens now, so a store accepted earlier is visible.
            r_rdata   <= (r_we || r_err) ? 32'd0 : w_mem_rdata;
            r_rsp_err <= r_err;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            r_rdata   <= 32'd0;
            r_rsp_err <= 1'b0;
          end
        end
        default: begin
          r_cnt <= 4'd0;
        end
      endcase
    end
  end

  assign bus.rsp_rdata_o = r_rdata;
  assign bus.rsp_err_o   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_responder
// Purpose : Scoreboard bench for mem_responder. Two instances: LATENCY=2
//           (dut2) and LATENCY=1 (dut1). Drivers push expected responses on
//           accept; per-instance monitors pop and compare on handshake.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  exp_t q1[$];
  exp_t q2[$];

  logic        pv  [1:2];
  logic [31:0] prd [1:2];
  logic        hs  [1:2];

  mem_responder_if if1();
  mem_responder_if if2();

  mem_responder #(.DEPTH_WORDS(128), .LATENCY(1)) u_dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if1)
  );

  mem_responder #(.DEPTH_WORDS(128), .LATENCY(2)) u_dut2 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One monitor step for instance s; called on every falling edge.
  task automatic mon_step(input int s, input int lat, input logic v, input logic rdy_o,
                          input logic rrdy, input logic [31:0] rd, input logic e);
    exp_t f;
    bit   empty;
    if (rst) begin
      pv[s] = 1'b0;
      hs[s] = 1'b0;
      return;
    end
    if (hs[s]) begin
      chk($sformatf("dut%0d ready_after_hs", s), {31'd0, rdy_o}, 32'd1);
      chk($sformatf("dut%0d valid_after_hs", s), {31'd0, v}, 32'd0);
      hs[s] = 1'b0;
    end
    if (v) begin
      chk($sformatf("dut%0d ready_low_in_resp", s), {31'd0, rdy_o}, 32'd0);
      empty = (s == 1) ? (q1.size() == 0) : (q2.size() == 0);
      if (empty) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL dut%0d unexpected_rsp: got valid with rdata 0x%08h required no response", s, rd);
      end else begin
        f = (s == 1) ? q1[0] : q2[0];
        if (!pv[s]) begin
          chk($sformatf("dut%0d latency", s), cyc, f.acc + lat);
        end else begin
          chk($sformatf("dut%0d stable_rdata", s), rd, prd[s]);
        end
        if (rrdy) begin
          chk($sformatf("dut%0d rdata", s), rd, f.rdata);
          chk($sformatf("dut%0d err", s), {31'd0, e}, {31'd0, f.err});
          if (s == 1) void'(q1.pop_front());
          else        void'(q2.pop_front());
          hs[s] = 1'b1;
        end
      end
    end
    pv[s]  = v;
    prd[s] = rd;
  endtask

  always @(negedge clk) begin
    mon_step(1, 1, if1.rsp_valid_o, if1.req_ready_o, if1.rsp_ready_i, if1.rsp_rdata_o, if1.rsp_err_o);
    mon_step(2, 2, if2.rsp_valid_o, if2.req_ready_o, if2.rsp_ready_i, if2.rsp_rdata_o, if2.rsp_err_o);
  end

  task automatic drive_req(input int s, input logic v, input logic we,
                           input logic [31:0] addr, input logic [31:0] wd);
    if (s == 1) begin
      if1.req_valid_i = v; if1.req_we_i = we; if1.req_addr_i = addr; if1.req_wdata_i = wd;
    end else begin
      if2.req_valid_i = v; if2.req_we_i = we; if2.req_addr_i = addr; if2.req_wdata_i = wd;
    end
  endtask

  // Present a request until accepted; push its expected response on accept.
  task automatic issue(input int s, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    exp_t x;
    bit   done;
    int   budget;
    done   = 0;
    budget = 0;
    @(posedge clk); #1;
    drive_req(s, 1'b1, we, addr, wd);
    while (!done) begin
      @(negedge clk);
      if ((s == 1) ? if1.req_ready_o : if2.req_ready_o) begin
        x.rdata = exp_rd;
        x.err   = exp_err;
        x.acc   = cyc + 1;
        if (s == 1) q1.push_back(x);
        else        q2.push_back(x);
        done = 1;
      end else if (++budget > 50) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL dut%0d accept_timeout: got no req_ready required accept", s);
        done = 1;
      end
      @(posedge clk); #1;
    end
    drive_req(s, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic wait_idle(input int s);
    int budget;
    budget = 0;
    while (((s == 1) ? q1.size() : q2.size()) != 0) begin
      @(negedge clk);
      if (++budget > 100) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL dut%0d rsp_timeout: got no response required %0d pending", s,
                 (s == 1) ? q1.size() : q2.size());
        if (s == 1) q1.delete();
        else        q2.delete();
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int budget;
    checks = 0;
    errors = 0;
    pv[1] = 0; pv[2] = 0; prd[1] = 0; prd[2] = 0; hs[1] = 0; hs[2] = 0;
    drive_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_req(2, 1'b0, 1'b0, 32'd0, 32'd0);
    if1.rsp_ready_i = 1'b1;
    if2.rsp_ready_i = 1'b1;
    rst = 1'b1;
    #1;
    // Reset values
    chk("reset req_ready", {31'd0, if2.req_ready_o}, 32'd1);
    chk("reset rsp_valid", {31'd0, if2.rsp_valid_o}, 32'd0);
    chk("reset rsp_rdata", if2.rsp_rdata_o, 32'd0);
    chk("reset rsp_err", {31'd0, if2.rsp_err_o}, 32'd0);
    chk("reset dut1 req_ready", {31'd0, if1.req_ready_o}, 32'd1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: store then load
    issue(2, 1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
    wait_idle(2);
    issue(2, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
    wait_idle(2);

    // 2: misaligned store is rejected and leaves memory alone
    issue(2, 1'b1, 32'h13, 32'h1, 32'd0, 1'b1);
    wait_idle(2);
    issue(2, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
    wait_idle(2);

    // 3: out of range, plus the last valid word
    issue(2, 1'b0, 32'h200, 32'd0, 32'd0, 1'b1);
    wait_idle(2);
    issue(2, 1'b1, 32'h1FC, 32'hCAFEF00D, 32'd0, 1'b0);
    wait_idle(2);
    issue(2, 1'b0, 32'h1FC, 32'd0, 32'hCAFEF00D, 1'b0);
    wait_idle(2);

    // 4: response backpressure with an ignored request pulse
    @(posedge clk); #1 if2.rsp_ready_i = 1'b0;
    issue(2, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
    budget = 0;
    while (!if2.rsp_valid_o && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 1) drive_req(2, 1'b1, 1'b1, 32'h10, 32'h0);
      if (i == 2) drive_req(2, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    if2.rsp_ready_i = 1'b1;
    wait_idle(2);
    issue(2, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
    wait_idle(2);

    // 5: minimum latency, back-to-back stores then loads
    issue(1, 1'b1, 32'h0, 32'h11111111, 32'd0, 1'b0);
    issue(1, 1'b1, 32'h4, 32'h22222222, 32'd0, 1'b0);
    issue(1, 1'b0, 32'h0, 32'd0, 32'h11111111, 1'b0);
    issue(1, 1'b0, 32'h4, 32'd0, 32'h22222222, 1'b0);
    wait_idle(1);

    // 6: reset during WAIT of a load
    issue(2, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midreset req_ready", {31'd0, if2.req_ready_o}, 32'd1);
    chk("midreset rsp_valid", {31'd0, if2.rsp_valid_o}, 32'd0);
    q2.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    issue(2, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
    wait_idle(2);
    issue(1, 1'b0, 32'h4, 32'd0, 32'h22222222, 1'b0);
    wait_idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
